rr_arb16: RTL and testbench
===========================

# rr_arb16

Round-robin arbiter that shares the 4-to-16 decoder output bank among 16 requesters. It selects one requester at a time and drives the granted index (`gnt_idx`) and enable (`gnt_vld`) into the two-level 4-to-16 decoder, whose one-hot output selects the owner. It also presents the same one-hot grant directly. Fairness comes from a rotating priority pointer; an optional hold limit forces rotation so no single requester can monopolise the resource.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum consecutive cycles one grant may be held; legal range 0..255; 0 = unlimited.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  [0:15]  request lines; bit i = requester i; level-sensitive.
- `gnt`  out  [0:15]  one-hot grant; bit i high = requester i owns the resource; all-zero when idle.
- `gnt_idx`  out  [3:0]  binary index of the current owner; feeds the decoder `w` input.
- `gnt_vld`  out  1  high while any grant is active; feeds the decoder `e` input.

All outputs are registered.

## Operation
- State register: IDLE, GRANT.
- Internal registers:
  - `ptr[3:0]`: highest-priority index for the next arbitration.
  - `cnt[7:0]`: hold counter.
- IDLE:
  - If `req` == 0: stay in IDLE.
  - Else: pick the first i with `req[i]`=1, searching `ptr`, `ptr`+1, …, 15, 0, …, `ptr`-1 (mod 16).
  - On that clock edge:
    - `gnt_idx` <= i, `gnt[i]` <= 1 (all other bits 0).
    - `gnt_vld` <= 1, `cnt` <= 0.
    - Next state GRANT.
- GRANT, with owner o = `gnt_idx`:
  - Release condition: `req[o]`=0, OR (`HOLD_MAX` != 0 AND `cnt` == `HOLD_MAX`-1).
  - On release:
    - `gnt` <= 0, `gnt_vld` <= 0.
    - `ptr` <= (o+1) mod 16, wrapping 15 to 0.
    - Next state IDLE.
    - `gnt_idx` keeps o.
  - Otherwise: `cnt` <= `cnt`+1 (saturating at 255; relevant only when `HOLD_MAX`=0). Stay in GRANT.
  - Requests from other requesters never pre-empt the owner.
- Every release is followed by exactly one IDLE cycle. Arbitration happens only in IDLE.
- Invariants:
  - `gnt` is always zero or one-hot.
  - `gnt_vld` == |`gnt`.
  - When `gnt_vld`=1, `gnt[gnt_idx]`=1.

## Timing
- Reset (`resetn`=0, asynchronous, takes effect immediately):
  - state = IDLE.
  - `gnt` = 16'h0000, `gnt_idx` = 0, `gnt_vld` = 0.
  - `ptr` = 0, `cnt` = 0.
- Reset asserted mid-grant drops the grant immediately. The owner gets no further cycles, and the pointer returns to 0.
- Grant latency: a request sampled high at edge k in IDLE is granted from edge k; outputs are visible in the cycle after k.
- Hold: with `req[o]` held high and `HOLD_MAX`=H>0, `gnt_vld` stays high for exactly H cycles, then low for 1 cycle.
- Request drop: if `req[o]` is sampled low at edge k, the grant clears at edge k. The owner therefore must not rely on the grant in the cycle after deasserting its request.
- Back-to-back rotation period with all requesters active: H+1 cycles per requester, 16·(H+1) cycles per full round.
- Simultaneous events:
  - If `req[o]` falls in the same cycle that `cnt` reaches H-1, the result is a single release; `ptr` = o+1.
  - A request that rises and falls entirely within a GRANT period by another requester is never granted. Requests are not latched.

## Test plan
- Reset: drive `resetn`=0 with `req`=16'hFFFF. Required: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0. After release, first grant goes to index 0.
- Single requester: raise `req[5]` for 3 cycles, `HOLD_MAX`=8. Required:
  - `gnt_idx`=5 and `gnt`=one-hot bit 5 for exactly 3 cycles, then `gnt_vld`=0.
  - Next arbitration starts at `ptr`=6.
- Full rotation: hold `req`=all ones with `HOLD_MAX`=8. Required:
  - Grants in order 0,1,2,…,15,0, each 8 cycles long, separated by 1 idle cycle.
  - Index 0 is re-granted after a 144-cycle period.
- Wrap-around: after owner 15 releases, present `req[0]`=`req[14]`=1. Required: the next grant is index 0.
- Unlimited hold: `HOLD_MAX`=0, hold `req[3]` for 300 cycles while `req[4]`=1. Required:
  - `gnt_idx`=3 for all 300 cycles with no release; `cnt` saturates at 255.
  - `req[4]` is granted 2 cycles after `req[3]` drops.
- Reset mid-grant: while owner 9 holds the grant, pulse `resetn` low between clock edges. Required:
  - Outputs are zero immediately.
  - After reset, with `req[9]` and `req[2]` both high, index 2 is granted first because `ptr`=0.

Source files
------------

// File: rtl/rr_arb16.sv
// -----------------------------------------------------------------------------
// rr_arb16 -- 16-way round-robin arbiter with optional hold limit.
//
// One requester at a time owns a shared resource (the 4-to-16 decoder bank).
// The owner's binary index and a valid strobe drive the decoder, and the same
// grant is also presented one-hot. A rotating priority pointer gives fairness.
// When HOLD_MAX is nonzero, a grant is force-released after HOLD_MAX cycles so
// that no requester can monopolise the resource. Every release is followed by
// exactly one idle cycle, and arbitration only happens in that idle state.
//
// Parameters
//   HOLD_MAX  maximum consecutive grant cycles (0..255); 0 = unlimited
//
// Ports
//   clk      in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   req      in   [0:15] level-sensitive requests, bit i = requester i
//   gnt      out  [0:15] registered one-hot grant, all-zero when idle
//   gnt_idx  out  [3:0]  registered binary index of the (last) owner
//   gnt_vld  out  registered, high while a grant is active
// -----------------------------------------------------------------------------
module rr_arb16 #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [0:15] req,
   output logic [0:15] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_vld
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Last counter value of a grant; only meaningful when the limit is enabled.
   localparam logic       HOLD_EN   = (HOLD_MAX != 0);
   localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

   logic [0:0]  state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [0:15] gnt_q, gnt_d;
   logic [3:0]  gnt_idx_q, gnt_idx_d;
   logic        gnt_vld_q, gnt_vld_d;

   // Requests rotated so that bit 0 is the requester at the priority pointer.
   // The 4-bit addition wraps 15 -> 0 on its own.
   logic [15:0] rot_req;
   logic [3:0]  pick_off;
   logic        pick_found;
   logic [3:0]  pick_idx;
   logic [0:15] pick_onehot;
   logic        release_grant;

   for (genvar gi = 0; gi < 16; gi++) begin : g_rot
      assign rot_req[gi] = req[4'(ptr_q + 4'(gi))];
   end

   // Lowest set bit of the rotated vector = first requester at or after ptr.
   always_comb begin
      pick_off = 4'd0;
      for (int k = 15; k >= 0; k--) begin
         if (rot_req[k]) begin
            pick_off = 4'(k);
         end
      end
   end

   assign pick_found = |rot_req;
   assign pick_idx   = ptr_q + pick_off;

   for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == 4'(gi));
   end

   // Owner dropping its request and the hold limit expiring in the same cycle
   // collapse into one release.
   assign release_grant = !req[gnt_idx_q] || (HOLD_EN && (cnt_q == HOLD_LAST));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      gnt_vld_d = gnt_vld_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d   = ST_GRANT;
               gnt_idx_d = pick_idx;
               gnt_d     = pick_onehot;
               gnt_vld_d = 1'b1;
               cnt_d     = 8'd0;
            end
         end
         ST_GRANT: begin
            if (release_grant) begin
               // gnt_idx deliberately keeps the old owner.
               state_d   = ST_IDLE;
               gnt_d     = '0;
               gnt_vld_d = 1'b0;
               ptr_d     = gnt_idx_q + 4'd1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 4'd0;
         cnt_q     <= 8'd0;
         gnt_q     <= '0;
         gnt_idx_q <= 4'd0;
         gnt_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_vld_q <= gnt_vld_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = gnt_idx_q;
   assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arb16.sv
// -----------------------------------------------------------------------------
// tb_rr_arb16 -- bench for rr_arb16.
//
// Two instances share clock, reset and requests: unit 0 with HOLD_MAX=8 and
// unit 1 with HOLD_MAX=0 (unlimited). Each unit has a cycle-level reference
// model that tracks the current owner (or -1 when idle), how many cycles the
// grant has been visible, and the next priority position.
// -----------------------------------------------------------------------------
module tb_rr_arb16;

   logic        clk;
   logic        resetn;
   logic [0:15] req;

   logic [0:15] gnt_a, gnt_b;
   logic [3:0]  idx_a, idx_b;
   logic        vld_a, vld_b;

   rr_arb16 #(.HOLD_MAX(8)) dut_a (
      .clk(clk), .resetn(resetn), .req(req),
      .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a)
   );

   rr_arb16 #(.HOLD_MAX(0)) dut_b (
      .clk(clk), .resetn(resetn), .req(req),
      .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // Reference model state, one entry per unit.
   int hold_lim[2] = '{8, 0};
   int m_owner[2];   // -1 = idle
   int m_held[2];    // cycles the current grant has been visible
   int m_ptr[2];     // first index searched at the next arbitration
   int m_idx[2];     // last owner index presented on gnt_idx

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_owner[u] = -1;
         m_held[u]  = 0;
         m_ptr[u]   = 0;
         m_idx[u]   = 0;
      end
   endtask

   task automatic model_step(input int u, input logic [0:15] r);
      if (m_owner[u] < 0) begin
         for (int k = 0; k < 16; k++) begin
            int j;
            j = (m_ptr[u] + k) % 16;
            if (m_owner[u] < 0 && r[j]) begin
               m_owner[u] = j;
               m_idx[u]   = j;
               m_held[u]  = 1;
            end
         end
      end else if (!r[m_owner[u]] || (hold_lim[u] != 0 && m_held[u] == hold_lim[u])) begin
         m_ptr[u]   = (m_owner[u] + 1) % 16;
         m_owner[u] = -1;
      end else begin
         m_held[u] = m_held[u] + 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string step);
      logic [0:15] eg;
      for (int u = 0; u < 2; u++) begin
         eg = '0;
         if (m_owner[u] >= 0) eg[m_owner[u]] = 1'b1;
         if (u == 0) begin
            chk($sformatf("%s.u0.gnt", step), 32'(gnt_a), 32'(eg));
            chk($sformatf("%s.u0.idx", step), 32'(idx_a), 32'(m_idx[u]));
            chk($sformatf("%s.u0.vld", step), 32'(vld_a), 32'(m_owner[u] >= 0));
         end else begin
            chk($sformatf("%s.u1.gnt", step), 32'(gnt_b), 32'(eg));
            chk($sformatf("%s.u1.idx", step), 32'(idx_b), 32'(m_idx[u]));
            chk($sformatf("%s.u1.vld", step), 32'(vld_b), 32'(m_owner[u] >= 0));
         end
      end
   endtask

   // One clock: model follows the edge, outputs are compared on the falling edge.
   task automatic tick(input string step);
      @(posedge clk);
      for (int u = 0; u < 2; u++) model_step(u, req);
      @(negedge clk);
      check_all(step);
   endtask

   initial begin
      int  prev_owner;
      bit  found;

      // Reset with every requester active.
      resetn = 1'b0;
      req    = 16'hFFFF;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      resetn = 1'b1;

      // Full rotation under constant requests; after owner 15 releases on
      // unit 0, present only requesters 0 and 14.
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         prev_owner = m_owner[0];
         tick("rotate");
         if (prev_owner == 15 && m_owner[0] < 0) found = 1'b1;
      end
      chk("wrap_reached", 32'(found), 32'd1);
      req = '0;
      req[0]  = 1'b1;
      req[14] = 1'b1;
      for (int c = 0; c < 4; c++) tick("wrap");

      // Single requester 5 for three cycles, then 4 and 7 to probe the pointer.
      req = '0;
      for (int c = 0; c < 3; c++) tick("idle1");
      req[5] = 1'b1;
      for (int c = 0; c < 3; c++) tick("single5");
      req = '0;
      tick("single5_rel");
      tick("single5_idle");
      req[4] = 1'b1;
      req[7] = 1'b1;
      for (int c = 0; c < 4; c++) tick("ptr6");

      // Long hold by requester 3 with requester 4 waiting.
      req = '0;
      for (int c = 0; c < 2; c++) tick("idle2");
      req[3] = 1'b1;
      req[4] = 1'b1;
      for (int c = 0; c < 300; c++) tick("hold3");
      req[3] = 1'b0;
      for (int c = 0; c < 5; c++) tick("after3");

      // Owner 9 interrupted by an asynchronous reset pulse between edges.
      req = '0;
      for (int c = 0; c < 2; c++) tick("idle3");
      req[9] = 1'b1;
      for (int c = 0; c < 3; c++) tick("own9");
      #2 resetn = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      #1 resetn = 1'b1;
      req[2] = 1'b1;
      for (int c = 0; c < 4; c++) tick("post_rst");

      // Random traffic, with requests redrawn only occasionally so grants
      // run long enough to reach the hold limit.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) req = 16'($urandom & $urandom);
         tick("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
